// File: rtl/lag_meter_if.sv
// Bundle of control, sensor and result signals for the lag_meter engine.
// The engine side uses the slave modport; the stimulus side uses master.
interface lag_meter_if #(
    parameter int unsigned CHANNELS  = 1,
    parameter int unsigned CNT_WIDTH = 24
);
    logic                          enable;
    logic                          start;
    logic [CHANNELS-1:0]           sensor;
    logic                          busy;
    logic                          result_valid;
    logic                          avg_valid;
    logic [CHANNELS-1:0]           timeout_flag;
    logic [CHANNELS*CNT_WIDTH-1:0] latency_last;
    logic [CHANNELS*CNT_WIDTH-1:0] latency_avg;
    logic [CHANNELS*CNT_WIDTH-1:0] latency_min;
    logic [CHANNELS*CNT_WIDTH-1:0] latency_max;

    modport master (
        output enable, start, sensor,
        input  busy, result_valid, avg_valid, timeout_flag,
        input  latency_last, latency_avg, latency_min, latency_max
    );

    modport slave (
        input  enable, start, sensor,
        output busy, result_valid, avg_valid, timeout_flag,
        output latency_last, latency_avg, latency_min, latency_max
    );
endinterface

// File: rtl/lag_meter.sv
// Multi-channel input-lag meter: conditions photo-sensor inputs, timestamps the
// first rising edge after a flash start and keeps last/average/min/max per channel.
module lag_meter #(
    parameter int unsigned          CHANNELS   = 1,
    parameter int unsigned          CNT_WIDTH  = 24,
    parameter int unsigned          FILTER_LEN = 4,
    parameter int unsigned          AVG_LOG2   = 4,
    parameter logic [CNT_WIDTH-1:0] TIMEOUT    = CNT_WIDTH'(8_000_000)
) (
    input  logic        clock,
    input  logic        reset,
    lag_meter_if.slave  bus
);

    localparam int unsigned DB_W  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned ACC_W = CNT_WIDTH + AVG_LOG2;
    localparam int unsigned RC_W  = AVG_LOG2 + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(FILTER_LEN - 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE, UPDATE} state_t;

    state_t state, state_next;

    logic [CHANNELS-1:0]  sync1, sync2, filt, filt_d;
    logic [DB_W-1:0]      dbc [CHANNELS];

    logic [CNT_WIDTH-1:0] counter;
    logic [CHANNELS-1:0]  done, cap_hit, done_next;
    logic [CNT_WIDTH-1:0] cap [CHANNELS];
    logic                 all_done, at_timeout, start_accept;

    logic [ACC_W-1:0]     acc     [CHANNELS];
    logic [CNT_WIDTH-1:0] run_min [CHANNELS];
    logic [CNT_WIDTH-1:0] run_max [CHANNELS];
    logic [RC_W-1:0]      round_cnt;
    logic                 avg_pending;

    logic                 busy, result_valid, avg_valid;
    logic [CHANNELS-1:0]  timeout_flag;
    logic [CNT_WIDTH-1:0] last_lat [CHANNELS];
    logic [CNT_WIDTH-1:0] avg_lat  [CHANNELS];
    logic [CNT_WIDTH-1:0] min_lat  [CHANNELS];
    logic [CNT_WIDTH-1:0] max_lat  [CHANNELS];

    // Capture qualification: only fresh 0->1 filtered edges while measuring
    always_comb begin
        cap_hit = '0;
        if (state == MEASURE) begin
            cap_hit = filt & ~filt_d & ~done;
        end
        done_next    = done | cap_hit;
        all_done     = &done_next;
        at_timeout   = (counter == TIMEOUT);
        start_accept = (state == ARMED) && (state_next == MEASURE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.enable) state_next = ARMED;
            end
            ARMED: begin
                if (!bus.enable)   state_next = IDLE;
                else if (bus.start) state_next = MEASURE;
            end
            MEASURE: begin
                if (!bus.enable)                 state_next = IDLE;
                else if (all_done || at_timeout) state_next = UPDATE;
            end
            UPDATE: begin
                state_next = bus.enable ? ARMED : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Two-flop synchroniser followed by a consecutive-sample debouncer
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            filt   <= '0;
            filt_d <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                dbc[i] <= '0;
            end
        end else begin
            sync1  <= bus.sensor;
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < CHANNELS; i++) begin
                if (sync2[i] != filt[i]) begin
                    if (dbc[i] == DB_LAST) begin
                        filt[i] <= ~filt[i];
                        dbc[i]  <= '0;
                    end else begin
                        dbc[i]  <= dbc[i] + DB_W'(1);
                    end
                end else begin
                    dbc[i] <= '0;
                end
            end
        end
    end

    // Round counter and per-channel first-edge timestamps
    always_ff @(posedge clock) begin
        if (!reset) begin
            counter <= '0;
            done    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cap[i] <= '0;
            end
        end else if (start_accept) begin
            counter <= '0;
            done    <= '0;
        end else if (state == MEASURE) begin
            counter <= counter + CNT_WIDTH'(1);
            done    <= done_next;
            for (int i = 0; i < CHANNELS; i++) begin
                if (cap_hit[i]) cap[i] <= counter;
            end
        end
    end

    // Result publication, window statistics and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            busy         <= 1'b0;
            result_valid <= 1'b0;
            avg_valid    <= 1'b0;
            timeout_flag <= '0;
            round_cnt    <= '0;
            avg_pending  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                last_lat[i] <= '0;
                avg_lat[i]  <= '0;
                min_lat[i]  <= '0;
                max_lat[i]  <= '0;
                acc[i]      <= '0;
                run_min[i]  <= '1;
                run_max[i]  <= '0;
            end
        end else begin
            busy         <= (state_next == ARMED) || (state_next == MEASURE);
            result_valid <= 1'b0;
            avg_valid    <= 1'b0;

            if (start_accept) begin
                timeout_flag <= '0;
            end

            if ((state == MEASURE) && (state_next == UPDATE)) begin
                result_valid <= 1'b1;
                for (int i = 0; i < CHANNELS; i++) begin
                    if (done_next[i]) begin
                        last_lat[i] <= cap_hit[i] ? counter : cap[i];
                    end else begin
                        last_lat[i]     <= '1;
                        timeout_flag[i] <= 1'b1;
                    end
                end
            end

            // Any timed-out channel disqualifies the whole round from the window
            if ((state == UPDATE) && (timeout_flag == '0)) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    acc[i] <= acc[i] + ACC_W'(last_lat[i]);
                    if (last_lat[i] < run_min[i]) run_min[i] <= last_lat[i];
                    if (last_lat[i] > run_max[i]) run_max[i] <= last_lat[i];
                end
                round_cnt <= round_cnt + RC_W'(1);
                if (round_cnt == RC_LAST) avg_pending <= 1'b1;
            end

            if (avg_pending) begin
                avg_pending <= 1'b0;
                avg_valid   <= 1'b1;
                round_cnt   <= '0;
                for (int i = 0; i < CHANNELS; i++) begin
                    avg_lat[i] <= CNT_WIDTH'(acc[i] >> AVG_LOG2);
                    min_lat[i] <= run_min[i];
                    max_lat[i] <= run_max[i];
                    acc[i]     <= '0;
                    run_min[i] <= '1;
                    run_max[i] <= '0;
                end
            end
        end
    end

    assign bus.busy         = busy;
    assign bus.result_valid = result_valid;
    assign bus.avg_valid    = avg_valid;
    assign bus.timeout_flag = timeout_flag;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_flat
        assign bus.latency_last[g*CNT_WIDTH +: CNT_WIDTH] = last_lat[g];
        assign bus.latency_avg[g*CNT_WIDTH +: CNT_WIDTH]  = avg_lat[g];
        assign bus.latency_min[g*CNT_WIDTH +: CNT_WIDTH]  = min_lat[g];
        assign bus.latency_max[g*CNT_WIDTH +: CNT_WIDTH]  = max_lat[g];
    end

endmodule

// File: tb/tb_lag_meter.sv
// Scoreboard bench for lag_meter: rounds push expected results, a negedge
// monitor pops and compares on result_valid / avg_valid.
module tb_lag_meter;

    localparam int unsigned CH   = 2;
    localparam int unsigned CW   = 24;
    localparam int unsigned FL   = 4;
    localparam int unsigned AL   = 2;
    localparam int          TO   = 1000;
    localparam int          PIPE = 2 + FL;
    localparam int unsigned VW   = CH * CW;

    typedef logic [VW-1:0] vec_t;
    typedef struct { vec_t lat; logic [CH-1:0] to; int delay; } exp_t;
    typedef struct { vec_t avg; vec_t mn; vec_t mx; } avg_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    lag_meter_if #(.CHANNELS(CH), .CNT_WIDTH(CW)) bus ();

    lag_meter #(
        .CHANNELS(CH), .CNT_WIDTH(CW), .FILTER_LEN(FL),
        .AVG_LOG2(AL), .TIMEOUT(CW'(TO))
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    exp_t exp_q[$];
    avg_t avg_q[$];
    vec_t win[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   t0         = 0;
    int   n_results  = 0;
    exp_t mon_e;
    avg_t mon_a;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input vec_t act, input vec_t req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the oldest expectation whenever the DUT reports
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (bus.result_valid === 1'b1) begin
                n_results++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_result: result_valid with nothing expected (t=%0t)", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("latency_last", bus.latency_last, mon_e.lat);
                    chk("timeout_flag", VW'(bus.timeout_flag), VW'(mon_e.to));
                    chk("result_delay", VW'(cyc - t0), VW'(mon_e.delay));
                end
            end
            if (bus.avg_valid === 1'b1) begin
                if (avg_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_avg: avg_valid with nothing expected (t=%0t)", $time);
                end else begin
                    mon_a = avg_q.pop_front();
                    chk("latency_avg", bus.latency_avg, mon_a.avg);
                    chk("latency_min", bus.latency_min, mon_a.mn);
                    chk("latency_max", bus.latency_max, mon_a.mx);
                end
            end
        end
    end

    // Reference statistics: recomputed from the whole window of good rounds
    function automatic void model_window(input vec_t lat);
        avg_t        a;
        vec_t        v;
        longint      sum;
        int unsigned mn, mx, x;
        win.push_back(lat);
        if (win.size() == (1 << AL)) begin
            for (int ch = 0; ch < CH; ch++) begin
                sum = 0;
                mn  = 32'hFFFF_FFFF;
                mx  = 0;
                for (int k = 0; k < win.size(); k++) begin
                    v = win[k];
                    x = int'(v[ch*CW +: CW]);
                    sum += x;
                    if (x < mn) mn = x;
                    if (x > mx) mx = x;
                end
                a.avg[ch*CW +: CW] = CW'(sum / (1 << AL));
                a.mn[ch*CW +: CW]  = CW'(mn);
                a.mx[ch*CW +: CW]  = CW'(mx);
            end
            avg_q.push_back(a);
            win.delete();
        end
    endfunction

    task automatic wait_results(input int target);
        int n = 0;
        while (n_results < target && n < TO + 100) begin
            @(posedge clock);
            n++;
        end
        compared++;
        if (n_results < target) begin
            mismatched++;
            $display("FAIL round_wait: results seen %0d, want %0d", n_results, target);
        end
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic settle();
        bus.enable = 1'b1;
        bus.start  = 1'b0;
        repeat (20) @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        t0        = cyc;
        bus.start = 1'b0;
    endtask

    // offset >= 0: raise that many cycles after start; -1: never; -2: high before start
    task automatic run_round(input int o0, input int o1, input int gl);
        int   offs [CH];
        exp_t e;
        int   tmax, target, lmax;
        bit   any_to;
        offs[0] = o0;
        offs[1] = o1;
        for (int ch = 0; ch < CH; ch++) bus.sensor[ch] = (offs[ch] == -2);
        settle();
        any_to = 1'b0;
        lmax   = 0;
        e.lat  = '0;
        e.to   = '0;
        for (int ch = 0; ch < CH; ch++) begin
            if (offs[ch] >= 0) begin
                e.lat[ch*CW +: CW] = CW'(offs[ch] + PIPE);
                if (offs[ch] + PIPE > lmax) lmax = offs[ch] + PIPE;
            end else begin
                e.lat[ch*CW +: CW] = '1;
                e.to[ch]           = 1'b1;
                any_to             = 1'b1;
            end
        end
        e.delay = (any_to ? TO : lmax) + 1;
        exp_q.push_back(e);
        if (!any_to) model_window(e.lat);
        target = n_results + 1;
        pulse_start();
        tmax = (gl >= 0) ? 25 : 0;
        for (int ch = 0; ch < CH; ch++) if (offs[ch] > tmax) tmax = offs[ch];
        for (int t = 0; t <= tmax; t++) begin
            if (t > 0) begin
                @(posedge clock);
                #1;
            end
            for (int ch = 0; ch < CH; ch++) if (offs[ch] == t) bus.sensor[ch] = 1'b1;
            if (gl >= 0) begin
                if (t == gl)     bus.sensor[0] = 1'b1;
                if (t == gl + 3) bus.sensor[0] = 1'b0;
                if (t == 20)     bus.start = 1'b1;
                if (t == 21)     bus.start = 1'b0;
            end
        end
        wait_results(target);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},   VW'(bus.busy), '0);
        chk({tag, "_rvalid"}, VW'(bus.result_valid), '0);
        chk({tag, "_avalid"}, VW'(bus.avg_valid), '0);
        chk({tag, "_tflag"},  VW'(bus.timeout_flag), '0);
        chk({tag, "_last"},   bus.latency_last, '0);
        chk({tag, "_avg"},    bus.latency_avg, '0);
        chk({tag, "_min"},    bus.latency_min, '0);
        chk({tag, "_max"},    bus.latency_max, '0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0, o1;
        reset      = 1'b0;
        bus.enable = 1'b0;
        bus.start  = 1'b0;
        bus.sensor = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_zero("reset");
        reset = 1'b1;

        run_round(100, 60, -1);
        run_round(50, 30, 10);
        run_round(-1, -1, -1);
        run_round(40, 70, -1);

        // enable dropped mid-measurement: no result, statistics kept
        bus.sensor = '0;
        settle();
        pulse_start();
        repeat (200) @(posedge clock);
        #1;
        bus.enable = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("abort_busy", VW'(bus.busy), '0);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (3) @(negedge clock);
        chk("idle_start_busy", VW'(bus.busy), '0);

        run_round(40, -2, -1);
        run_round(41, 10, -1);
        run_round(20, 5, -1);

        // reset at counter 500 clears the partially filled window as well
        bus.sensor = '0;
        settle();
        pulse_start();
        repeat (500) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_zero("midreset");
        win.delete();
        reset = 1'b1;

        run_round(10, 12, -1);
        run_round(20, 200, -1);
        run_round(-1, 3, -1);
        run_round(30, 0, -1);
        run_round(41, 77, -1);

        for (int r = 0; r < 12; r++) begin
            o0 = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 300));
            o1 = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 300));
            run_round(o0, o1, -1);
        end

        repeat (10) @(posedge clock);
        chk("pending_results", VW'(exp_q.size()), '0);
        chk("pending_avgs", VW'(avg_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lag_meter.md
Name: lag_meter

Overview:
- Multi-channel input-lag measurement engine for the tester datapath.
- Flow per round:
  - The video side issues a one-cycle start pulse on the first active line of a flash frame.
  - Each photo-sensor channel is synchronised and debounced, then timestamped on its first rising edge.
  - Results are accumulated into per-channel last/average/min/max figures.
- Parametrised successor to the single-sensor capture: adds channel count, counter width, debounce depth, averaging depth and timeout.

Parameters:
- CHANNELS, 1, number of independent sensor inputs (1..8).
- CNT_WIDTH, 24, latency counter width in clock cycles.
- FILTER_LEN, 4, consecutive equal synchronised samples needed to change the filtered sensor level (2..16).
- AVG_LOG2, 4, averaging window is 2^AVG_LOG2 good rounds.
- TIMEOUT, 24'd8_000_000, round abort count; must be below 2^CNT_WIDTH-1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous reset, active-low; all state is cleared on the first clock edge with reset=0.
- enable  in  1  arms the engine; 0 forces IDLE at the next edge.
- start  in  1  one-cycle flash-start pulse.
- sensor  in  CHANNELS  raw asynchronous sensor inputs.
- busy  out  1  high in ARMED or MEASURE.
- result_valid  out  1  one-cycle pulse when a round completes (good or timed out).
- avg_valid  out  1  one-cycle pulse when avg/min/max update.
- timeout_flag  out  CHANNELS  sticky per channel until the next round starts.
- latency_last  out  CHANNELS*CNT_WIDTH  last capture per channel; channel i at [i*CNT_WIDTH +: CNT_WIDTH].
- latency_avg  out  CHANNELS*CNT_WIDTH  window mean per channel.
- latency_min  out  CHANNELS*CNT_WIDTH  window minimum per channel.
- latency_max  out  CHANNELS*CNT_WIDTH  window maximum per channel.

Behaviour:
- Reset values:
  - All outputs 0.
  - Accumulators 0; round count 0.
  - Filtered sensor levels 0; FSM in IDLE.
- Input conditioning, per channel:
  - 2-FF synchroniser, then debounce counter.
  - Filtered level toggles after FILTER_LEN consecutive synchronised samples differ from it.
  - Fixed pipeline offset PIPE = 2+FILTER_LEN cycles is included in all results and is not compensated.
- FSM:
  - IDLE: go to ARMED when enable=1.
  - ARMED: on start=1, clear counter to 0, clear timeout_flag and capture-done bits, go to MEASURE next cycle.
  - MEASURE:
    - Counter increments every cycle.
    - A channel captures the counter on the cycle its filtered level shows a 0→1 edge; only the first edge per round counts.
    - Level already high when MEASURE is entered is not an edge.
    - When all channels are done, go to UPDATE.
    - If the counter reaches TIMEOUT first, each uncaptured channel sets timeout_flag, its latency_last becomes all ones, and the FSM goes to UPDATE.
  - UPDATE (one cycle):
    - Pulse result_valid and write latency_last.
    - If there was no timeout: add each capture to a CNT_WIDTH+AVG_LOG2 accumulator, update running min/max, increment round count.
    - Timed-out rounds are excluded from the statistics entirely.
    - When round count reaches 2^AVG_LOG2: in the next cycle latency_avg = acc>>AVG_LOG2 (truncating), latency_min/max take the running values, avg_valid pulses, accumulators/count/running min (to all ones) and max (to 0) reset.
    - Then return to ARMED (or to IDLE if enable=0).
- start outside ARMED is ignored.
- enable=0 mid-MEASURE aborts the round with no result_valid; accumulated statistics are retained.
- Reset mid-round clears everything, including statistics.
- start and a sensor edge in the same ARMED cycle: the edge is ignored.
- Counter never wraps, because TIMEOUT < 2^CNT_WIDTH-1.

Test Plan:
- Defaults, CHANNELS=1: reset low 3 cycles → all outputs 0, busy=0. Then enable=1, start pulse, sensor raised 100 cycles after start acceptance → result_valid once, latency_last=106, timeout_flag=0.
- Glitch rejection: a 3-cycle sensor pulse during MEASURE (FILTER_LEN=4) → no capture. Sensor then held high at offset 50 → latency_last=56.
- Timeout, TIMEOUT=1000: sensor stays low → result_valid at counter 1000, latency_last=24'hFFFFFF, timeout_flag=1, round count unchanged.
- Averaging, AVG_LOG2=2: four good rounds with raw offsets 10,20,30,41 → avg_valid once, avg=(16+26+36+47)>>2=31, min=16, max=47. A timeout round inserted mid-window does not count.
- CHANNELS=2: ch0 rises at 40, ch1 at 70 → one result_valid after ch1, latency_last={76,46}. Ch1 held high before start → ch1 times out, ch0=46.
- Reset asserted at counter 500 of MEASURE → next cycle in IDLE, busy=0, outputs 0. enable=0 mid-round → IDLE, no result_valid, stats kept.
